// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// DIR_UP / DIR_DN : encoding of the up_dn direction input.
// bin2gray        : binary to reflected Gray code. It works on 64 bits so that
//                   any WIDTH up to 64 can use it by casting in and out.
package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic logic [63:0] bin2gray(input logic [63:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle of the up/down modulo counter.
// Latency: n/a (wires only).
// Backpressure: none; every control input is sampled each clock.
//
// master : the block that drives the counter (en, up_dn, load, load_val,
//          mod_max, sat_mode) and observes its status.
// slave  : the counter itself (count, gray, wrap registered; at_max and
//          at_zero combinational from count).
interface updown_mod_counter_if #(
   parameter int WIDTH = 4
) ();

   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] mod_max;
   logic             sat_mode;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] gray;
   logic             at_max;
   logic             at_zero;
   logic             wrap;

   modport master (
      output en, up_dn, load, load_val, mod_max, sat_mode,
      input  count, gray, at_max, at_zero, wrap
   );

   modport slave (
      input  en, up_dn, load, load_val, mod_max, sat_mode,
      output count, gray, at_max, at_zero, wrap
   );

endinterface

// File: rtl/updown_mod_counter_bin2gray.sv
// Combinational binary to Gray converter for a WIDTH-bit value.
// Latency: zero (pure combinational).
// Backpressure: none.
//
// Ports: bin (WIDTH, in) binary value; gray (WIDTH, out) its Gray code.
// WIDTH is limited to 64 by the package helper it wraps.
module bin2gray_w
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = WIDTH'(bin2gray(64'(bin)));

endmodule

// File: rtl/updown_mod_counter.sv
// WIDTH-bit up/down counter with load, programmable terminal value, wrap or
// saturate mode, registered Gray copy and a one-cycle wrap pulse.
// Latency: one cycle from inputs to count/gray/wrap; at_max/at_zero are
// combinational from count. Backpressure: none, a step is taken whenever en.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries
// en, up_dn, load, load_val, mod_max, sat_mode in and count, gray, at_max,
// at_zero, wrap out.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int RESET_VALUE = 0
) (
   input  logic                clk,
   input  logic                rst,
   updown_mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] RST_CNT  = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] RST_GRAY = RST_CNT ^ (RST_CNT >> 1);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] nxt_cnt;
   logic [WIDTH-1:0] nxt_gray;
   logic             nxt_wrap;

   // Next-state mux: load beats enable; an out-of-range count (left behind
   // by lowering mod_max at run time) is pulled back to mod_max before any
   // normal up/down rule is considered. With mod_max = 0 the count sits at
   // 0 == mod_max, so wrap mode produces a wrap on every enabled step.
   always_comb begin
      nxt_cnt  = bus.count;
      nxt_wrap = 1'b0;
      if (bus.load) begin
         nxt_cnt = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;
      end else if (bus.en) begin
         if (bus.count > bus.mod_max) begin
            nxt_cnt = bus.mod_max;
         end else if (bus.up_dn == DIR_UP) begin
            if (bus.count == bus.mod_max) begin
               if (!bus.sat_mode) begin
                  nxt_cnt  = '0;
                  nxt_wrap = 1'b1;
               end
            end else begin
               nxt_cnt = bus.count + ONE;
            end
         end else begin
            if (bus.count == '0) begin
               if (!bus.sat_mode) begin
                  nxt_cnt  = bus.mod_max;
                  nxt_wrap = 1'b1;
               end
            end else begin
               nxt_cnt = bus.count - ONE;
            end
         end
      end
   end

   // Gray is taken from the next count so it lands on the same edge as count.
   bin2gray_w #(
      .WIDTH (WIDTH)
   ) u_b2g (
      .bin  (nxt_cnt),
      .gray (nxt_gray)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.count <= RST_CNT;
         bus.gray  <= RST_GRAY;
         bus.wrap  <= 1'b0;
      end else begin
         bus.count <= nxt_cnt;
         bus.gray  <= nxt_gray;
         bus.wrap  <= nxt_wrap;
      end
   end

   assign bus.at_max  = (bus.count == bus.mod_max);
   assign bus.at_zero = (bus.count == '0);

endmodule
